mips_wait_memory: RTL



---
 rtl/mips_mem_pkg.sv | 23 ++
 rtl/mips_word_ram.sv | 29 ++
 rtl/mips_wait_memory.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the multicycle MIPS memory port: FSM states,
// word geometry and the read/write encoding of r_wbar.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int LSB_W      = $clog2(WORD_BYTES);
  localparam int WAIT_W     = 4;

  localparam logic R_WBAR_READ  = 1'b1;
  localparam logic R_WBAR_WRITE = 1'b0;

  // A word access must have its byte-offset bits clear.
  function automatic logic is_misaligned(input logic [LSB_W-1:0] lsb);
    return lsb != '0;
  endfunction

endpackage

// File: rtl/mips_word_ram.sv
// Single-port synchronous word array. The read register only updates
// when re is high, so it holds across writes.
module mips_word_ram #(
  parameter int    DEPTH_LOG2 = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  // Registered read, cleared by reset so the port starts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/mips_wait_memory.sv
// Unified instruction/data memory with a programmable number of wait
// states and a req/ready handshake for the multicycle MIPS controller.
module mips_wait_memory
  import mips_mem_pkg::*;
#(
  parameter int    DEPTH_LOG2  = 10,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        r_wbar,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        misaligned,
  output logic        busy
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("mips_wait_memory: WAIT_CYCLES must be within 0..15");
  end

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);
  localparam logic [WAIT_W-1:0] ONE       = WAIT_W'(1);

  state_t                state_q, state_n;
  logic [WAIT_W-1:0]     cnt_q, cnt_n;
  logic                  accept, fire;

  logic [DEPTH_LOG2-1:0] idx_q, idx_sel;
  logic [31:0]           wdata_q, wdata_sel;
  logic                  r_wbar_q, r_wbar_sel;
  logic                  mis_q, mis_sel;
  logic                  we, re;

  // Address bits above the array size are deliberately ignored (wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:DEPTH_LOG2+LSB_W];

  // Control state: FSM and wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  // Next-state logic; fire marks the edge that enters RESP.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    accept  = 1'b0;
    fire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          cnt_n  = WAIT_LOAD;
          if (WAIT_CYCLES == 0) begin
            state_n = RESP;
            fire    = 1'b1;
          end else begin
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q != '0) cnt_n = cnt_q - ONE;
        if (cnt_q <= ONE) begin
          state_n = RESP;
          fire    = 1'b1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Request latches; later changes on the inputs have no effect.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q    <= addr[DEPTH_LOG2+LSB_W-1:LSB_W];
      wdata_q  <= wdata;
      r_wbar_q <= r_wbar;
      mis_q    <= is_misaligned(addr[LSB_W-1:0]);
    end
  end

  // With zero wait states the array is accessed on the acceptance edge,
  // so the live inputs must be used instead of the (not yet loaded) latches.
  always_comb begin
    if (state_q == IDLE) begin
      idx_sel    = addr[DEPTH_LOG2+LSB_W-1:LSB_W];
      wdata_sel  = wdata;
      r_wbar_sel = r_wbar;
      mis_sel    = is_misaligned(addr[LSB_W-1:0]);
    end else begin
      idx_sel    = idx_q;
      wdata_sel  = wdata_q;
      r_wbar_sel = r_wbar_q;
      mis_sel    = mis_q;
    end
  end

  assign we = fire && !mis_sel && (r_wbar_sel == R_WBAR_WRITE);
  assign re = fire && !mis_sel && (r_wbar_sel == R_WBAR_READ);

  mips_word_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .rst   (reset),
    .we    (we),
    .re    (re),
    .idx   (idx_sel),
    .wdata (wdata_sel),
    .rdata (rdata)
  );

  assign ready      = (state_q == RESP);
  assign misaligned = (state_q == RESP) && mis_q;
  assign busy       = (state_q != IDLE);

endmodule
